// File: rtl/afc_pkg.sv
// Shared definitions for the AFC loop: comparator codes and FSM state encoding.
package afc_pkg;

    // Comparator codes, also consumed by the band-search FSM.
    localparam logic [2:0] COMP_HOLD   = 3'b000;
    localparam logic [2:0] COMP_FREEZE = 3'b001;
    localparam logic [2:0] COMP_SLOW   = 3'b010;
    localparam logic [2:0] COMP_FAST   = 3'b100;

    // Frequency comparator sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_DECIDE  = 3'd3,
        ST_DONE    = 3'd4
    } afc_state_e;

endpackage

// File: rtl/afc_edge_counter.sv
// Synchronises the divided VCO into the clk domain, detects its rising edges
// and counts them with saturation. count_next is the value the counter takes
// at the coming edge, so the owner can capture a window's final count
// including an edge detected in the window's last cycle.
module afc_edge_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vco_div,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count_next
);

    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    logic             edge_s;
    logic             sat_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    // Two-flop synchroniser followed by a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= vco_div;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign edge_s = sync2_r & ~prev_r;
    assign sat_s  = &count_r;

    // Next count: clear wins, otherwise count enabled edges until all-ones.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (en && edge_s && !sat_s) begin
            count_next_s = count_r + CNT_W'(1'b1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Edge count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count_next = count_next_s;

endmodule

// File: rtl/afc_freq_comparator.sv
// AFC measurement front end: settle, count VCO edges over a fixed window,
// compare against target +/- TOL and issue a one-cycle FAST/SLOW/FREEZE code.
module afc_freq_comparator
    import afc_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int TOL           = 2,
    parameter int MAX_DECISIONS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vco_div,
    input  logic [CNT_W-1:0] target_count,
    output logic [2:0]       comp_out,
    output logic [CNT_W-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             forced
);

    localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DEC_W   = $clog2(MAX_DECISIONS + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYCLES - 1);
    localparam logic [DEC_W-1:0] DEC_LAST    = DEC_W'(MAX_DECISIONS - 1);
    localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W + 1)'(TOL);

    afc_state_e       state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [DEC_W-1:0] dec_cnt_r, dec_cnt_s;
    logic [CNT_W-1:0] target_r, target_s;
    logic [CNT_W-1:0] count_out_r, count_out_s;
    logic [2:0]       comp_r, comp_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             forced_r, forced_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W:0]   count_ext_s;
    logic [CNT_W:0]   upper_s;
    logic [CNT_W:0]   lower_s;
    logic [2:0]       verdict_s;

    afc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk        (clk),
        .rst        (rst),
        .vco_div    (vco_div),
        .clr        (cnt_clr_s),
        .en         (cnt_en_s),
        .count_next (cnt_next_s)
    );

    // One extra bit keeps target+TOL from overflowing; lower bound clamps at 0.
    assign count_ext_s = {1'b0, cnt_next_s};
    assign upper_s     = {1'b0, target_r} + TOL_EXT;
    assign lower_s     = ({1'b0, target_r} >= TOL_EXT) ? ({1'b0, target_r} - TOL_EXT)
                                                       : {(CNT_W + 1){1'b0}};

    // Raw verdict of the window that is closing this cycle.
    always_comb begin
        verdict_s = COMP_FREEZE;
        if (count_ext_s > upper_s) begin
            verdict_s = COMP_FAST;
        end else if (count_ext_s < lower_s) begin
            verdict_s = COMP_SLOW;
        end else begin
            verdict_s = COMP_FREEZE;
        end
    end

    // Sequencing: next state, timers, decision budget and next output values.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        dec_cnt_s   = dec_cnt_r;
        target_s    = target_r;
        count_out_s = count_out_r;
        comp_s      = COMP_HOLD;
        done_s      = done_r;
        forced_s    = forced_r;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s   = ST_SETTLE;
                    timer_s   = {TMR_W{1'b0}};
                    dec_cnt_s = {DEC_W{1'b0}};
                    target_s  = target_count;
                    done_s    = 1'b0;
                    forced_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                cnt_clr_s = 1'b1;
                if (timer_r == SETTLE_LAST) begin
                    state_s = ST_MEASURE;
                    timer_s = {TMR_W{1'b0}};
                end else begin
                    timer_s = timer_r + TMR_W'(1'b1);
                end
            end
            ST_MEASURE: begin
                cnt_en_s = 1'b1;
                if (timer_r == WIN_LAST) begin
                    state_s     = ST_DECIDE;
                    timer_s     = {TMR_W{1'b0}};
                    count_out_s = cnt_next_s;
                    dec_cnt_s   = dec_cnt_r + DEC_W'(1'b1);
                    // The last decision of the budget must end the search.
                    if ((verdict_s != COMP_FREEZE) && (dec_cnt_r == DEC_LAST)) begin
                        comp_s   = COMP_FREEZE;
                        forced_s = 1'b1;
                    end else begin
                        comp_s = verdict_s;
                    end
                end else begin
                    timer_s = timer_r + TMR_W'(1'b1);
                end
            end
            ST_DECIDE: begin
                timer_s = {TMR_W{1'b0}};
                if (comp_r == COMP_FREEZE) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = {TMR_W{1'b0}};
            end
        endcase
        busy_s = (state_s == ST_SETTLE) || (state_s == ST_MEASURE) || (state_s == ST_DECIDE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            timer_r     <= {TMR_W{1'b0}};
            dec_cnt_r   <= {DEC_W{1'b0}};
            target_r    <= {CNT_W{1'b0}};
            count_out_r <= {CNT_W{1'b0}};
            comp_r      <= COMP_HOLD;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            forced_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            dec_cnt_r   <= dec_cnt_s;
            target_r    <= target_s;
            count_out_r <= count_out_s;
            comp_r      <= comp_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            forced_r    <= forced_s;
        end
    end

    assign comp_out  = comp_r;
    assign count_out = count_out_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign forced    = forced_r;

endmodule

// File: tb/tb_afc_freq_comparator.sv
// Self-checking bench for afc_freq_comparator with a window-level reference model.
module tb_afc_freq_comparator;

    localparam int CNT_W   = 8;
    localparam int WIN     = 64;
    localparam int SETTLE  = 8;
    localparam int TOL     = 1;
    localparam int MAXD    = 6;
    localparam int PERIOD  = 1 + SETTLE + WIN;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [2:0] C_HOLD   = 3'b000;
    localparam logic [2:0] C_FREEZE = 3'b001;
    localparam logic [2:0] C_SLOW   = 3'b010;
    localparam logic [2:0] C_FAST   = 3'b100;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             vco_div = 1'b0;
    logic [CNT_W-1:0] target_count = '0;
    logic [2:0]       comp_out;
    logic [CNT_W-1:0] count_out;
    logic             busy, done, forced;

    logic       start4 = 1'b0;
    logic       vco4 = 1'b0;
    logic [3:0] target4 = 4'd8;
    logic [2:0] comp4;
    logic [3:0] count4;
    logic       busy4, done4, forced4;

    int n_checks = 0;
    int n_errors = 0;

    afc_freq_comparator #(.CNT_W(CNT_W), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SETTLE),
                          .TOL(TOL), .MAX_DECISIONS(MAXD)) dut (
        .clk(clk), .rst(rst), .start(start), .vco_div(vco_div), .target_count(target_count),
        .comp_out(comp_out), .count_out(count_out), .busy(busy), .done(done), .forced(forced));

    afc_freq_comparator #(.CNT_W(4), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SETTLE),
                          .TOL(TOL), .MAX_DECISIONS(MAXD)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .vco_div(vco4), .target_count(target4),
        .comp_out(comp4), .count_out(count4), .busy(busy4), .done(done4), .forced(forced4));

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus generators ----------------
    int          mode = 0;        // 0 level, 1 periodic, 2 burst, 3 band-controlled VCO
    logic        vco_level = 1'b0;
    int          per = 4;
    int          ph = 0;
    int          burst_left = 0;
    int          band = 8;
    int          step = 4;
    logic [15:0] acc = 16'd0;

    function automatic int inc_of(input int b);
        int v;
        v = b * 4096 - 20480;
        return (v < 1024) ? 1024 : v;
    endfunction

    initial forever begin
        @(negedge clk);
        vco4 = ~vco4;
        case (mode)
            1: begin ph = (ph + 1) % per; vco_div = (ph < per / 2); end
            2: begin
                if (burst_left > 0) begin
                    if (!vco_div) vco_div = 1'b1;
                    else begin vco_div = 1'b0; burst_left--; end
                end
            end
            3: begin acc = acc + 16'(inc_of(band)); vco_div = acc[15]; end
            default: vco_div = vco_level;
        endcase
    end

    // Binary-search band controller closing the loop in mode 3.
    initial forever begin
        @(posedge clk); #2;
        if (mode == 3 && comp_out != C_HOLD) begin
            if (comp_out == C_FAST) band -= step;
            else if (comp_out == C_SLOW) band += step;
            if (comp_out != C_FREEZE && step > 1) step = step / 2;
        end
    end

    // ---------------- reference model ----------------
    bit         v_hist [0:65535];
    int         cyc = -1;
    bit         m_valid = 0, m_active = 0, m_finish = 0, m_done = 0, m_forced = 0;
    int         m_s = 0, m_tgt = 0, m_ndec = 0, m_count = 0;
    logic [2:0] m_comp = C_HOLD;

    function automatic logic [2:0] classify(input int cnt, input int tgt);
        if (cnt > tgt + TOL) return C_FAST;
        if (cnt < tgt - TOL) return C_SLOW;
        return C_FREEZE;
    endfunction

    // Rising transitions of the sampled VCO that land in the window closing at
    // edge e, shifted by the two-sample synchroniser delay.
    function automatic int window_edges(input int e);
        int n;
        n = 0;
        for (int j = e - WIN - 1; j <= e - 2; j++)
            if (j >= 1 && v_hist[j] && !v_hist[j-1]) n++;
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    initial forever begin
        int r;
        logic [2:0] code;
        @(posedge clk);
        cyc++;
        v_hist[cyc] = vco_div;
        if (rst) begin
            m_valid = 1; m_active = 0; m_finish = 0; m_done = 0; m_forced = 0;
            m_count = 0; m_comp = C_HOLD;
        end else begin
            m_comp = C_HOLD;
            if (m_finish) begin
                m_finish = 0; m_active = 0; m_done = 1;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1; m_s = cyc; m_tgt = int'(target_count);
                    m_ndec = 0; m_forced = 0; m_done = 0;
                end
            end else begin
                r = cyc - m_s - SETTLE - WIN;
                if (r >= 0 && (r % PERIOD) == 0) begin
                    m_count = window_edges(cyc);
                    code = classify(m_count, m_tgt);
                    m_ndec++;
                    if (m_ndec == MAXD && code != C_FREEZE) begin
                        code = C_FREEZE; m_forced = 1;
                    end
                    m_comp = code;
                    if (code == C_FREEZE) m_finish = 1;
                end
            end
        end
        #1;
        if (m_valid) begin
            chk("comp_out", 32'(comp_out), 32'(m_comp));
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("forced", 32'(forced), 32'(m_forced));
            chk("count_out", 32'(count_out), 32'(m_count));
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic start_cal(input int tgt);
        @(negedge clk);
        start = 1'b1;
        target_count = CNT_W'(tgt);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the next comp_out pulse; optionally pokes start at wait cycle 'poke'.
    task automatic wait_pulse(input int budget, input int poke, output int n, output logic [2:0] code);
        n = 0;
        code = C_HOLD;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            start = (n == poke);
            if (n == poke) target_count = CNT_W'(100);
            if (comp_out != C_HOLD) begin
                code = comp_out;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    int         bn [3] = '{15, 17, 14};
    logic [2:0] bc [3] = '{C_FREEZE, C_FREEZE, C_SLOW};

    initial begin
        int n, k, tgt;
        logic [2:0] code;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset comp_out", 32'(comp_out), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset count_out", 32'(count_out), 32'(0));

        // Saturation with a 4-bit counter at VCO period 2.
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        n = 0;
        while (comp4 == C_HOLD && n < 200) begin @(posedge clk); #1; n++; end
        chk("sat pulse seen", 32'(n < 200), 32'(1));
        chk("sat count_out", 32'(count4), 32'(15));
        chk("sat comp_out", 32'(comp4), 32'(C_FAST));

        // Period 4: lock on first decision; start while busy is ignored.
        mode = 1; per = 4; ph = 0;
        repeat (5) @(posedge clk);
        start_cal(16);
        wait_pulse(200, 40, n, code);
        chk("p4 latency", 32'(n + 1), 32'(73));
        chk("p4 code", 32'(code), 32'(C_FREEZE));
        chk("p4 count", 32'(count_out), 32'(16));
        chk("p4 model count", 32'(m_count), 32'(16));
        @(posedge clk); #1;
        chk("p4 done", 32'(done), 32'(1));
        chk("p4 forced", 32'(forced), 32'(0));

        // Period 2: FAST, re-settle, next pulse 73 cycles later, then reset mid-measure.
        per = 2;
        start_cal(16);
        wait_pulse(200, -1, n, code);
        chk("p2 latency", 32'(n + 1), 32'(73));
        chk("p2 code", 32'(code), 32'(C_FAST));
        chk("p2 count", 32'(count_out), 32'(32));
        wait_pulse(200, -1, n, code);
        chk("p2 interval", 32'(n), 32'(73));
        chk("p2 code2", 32'(code), 32'(C_FAST));
        repeat (30) @(posedge clk);
        pulse_rst();
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort count_out", 32'(count_out), 32'(0));
        wait_pulse(150, -1, n, code);
        chk("abort no pulse", 32'(code), 32'(C_HOLD));

        // Period 8: SLOW.
        per = 8;
        start_cal(16);
        wait_pulse(200, -1, n, code);
        chk("p8 code", 32'(code), 32'(C_SLOW));
        chk("p8 count", 32'(count_out), 32'(8));
        pulse_rst();

        // Exact edge bursts around the tolerance band.
        mode = 0; vco_level = 1'b0;
        repeat (4) @(posedge clk);
        mode = 2;
        for (int i = 0; i < 3; i++) begin
            start_cal(16);
            repeat (10) @(posedge clk);
            burst_left = bn[i];
            wait_pulse(200, -1, n, code);
            chk("burst code", 32'(code), 32'(bc[i]));
            chk("burst count", 32'(count_out), 32'(bn[i]));
            repeat (2) @(posedge clk);
        end
        pulse_rst();

        // Constant VCO: budget exhausted, forced FREEZE.
        mode = 0; vco_level = 1'b1;
        start_cal(16);
        for (int i = 0; i < MAXD; i++) begin
            wait_pulse(200, -1, n, code);
            chk("const code", 32'(code), 32'((i < MAXD - 1) ? C_SLOW : C_FREEZE));
        end
        chk("const forced", 32'(forced), 32'(1));
        chk("const count", 32'(count_out), 32'(0));
        @(posedge clk); #1;
        chk("const done", 32'(done), 32'(1));

        // Closed loop with the band search.
        band = 8; step = 4; acc = 16'd0; mode = 3;
        repeat (2) @(posedge clk);
        start_cal(16);
        k = 0;
        code = C_HOLD;
        while (k < MAXD && code != C_FREEZE) begin
            wait_pulse(200, -1, n, code);
            k++;
            if (code == C_HOLD) break;
        end
        @(posedge clk); #3;
        chk("loop code", 32'(code), 32'(C_FREEZE));
        chk("loop band", 32'(band), 32'(9));
        chk("loop forced", 32'(forced), 32'(0));
        chk("loop done", 32'(done), 32'(1));

        // Randomised periods and targets against the model.
        mode = 1;
        for (int t = 0; t < 8; t++) begin
            per = $urandom_range(2, 12);
            ph  = $urandom_range(0, per - 1);
            tgt = (t == 0) ? 0 : $urandom_range(0, 40);
            repeat (2) @(posedge clk);
            start_cal(tgt);
            for (int d = 0; d < MAXD; d++) begin
                wait_pulse(100, (d == 0) ? $urandom_range(5, 70) : -1, n, code);
                chk("rand pulse seen", 32'(code != C_HOLD), 32'(1));
                if (code == C_FREEZE || code == C_HOLD) break;
                if (t % 3 == 2) begin
                    repeat ($urandom_range(1, 60)) @(posedge clk);
                    pulse_rst();
                    break;
                end
            end
            repeat (2) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
